esl_stream_encoder: RTL and testbench
=====================================

# esl_stream_encoder

Binary-to-ESL stream encoder: accepts one binary operand pair (numerator, denominator) per job over a valid/ready handshake. It emits a 2^`BIN_LEN`-beat extended-stochastic-logic bitstream pair (x, y) with exact ones-counts, under downstream backpressure. It sits in front of the processing-element array and drives each element's `input_val_x`/`input_val_y`. Its output stream is the form that the ESL bipolar divider converts back to binary.

## Interface
Parameters:
- `N`, default `BIN_LEN`: operand width; stream length is 2^N beats.
- `Y_SEED`, default 1: y-source LFSR state loaded at every job start. Any N-bit value, including 0, is legal.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `in_valid`  in  1  job request.
- `in_ready`  out  1  high only in IDLE.
- `in_num`  in  N  x probability numerator; P(x)=in_num/2^N.
- `in_den`  in  N  y probability numerator; P(y)=in_den/2^N.
- `in_y_one`  in  1  force y=1 on every beat, as for a binary weight/identity denominator; `in_den` is ignored.
- `out_valid`  out  1  current beat is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_x`  out  1  x stream bit.
- `out_y`  out  1  y stream bit.
- `out_last`  out  1  final beat (beat index 2^N-1) of the job.

## Operation
- FSM has two states, IDLE and STREAM.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&`in_ready`: register `in_num`, `in_den` and `in_y_one`, clear beat counter `cnt`, load the LFSR with `Y_SEED`, and go to STREAM.
- STREAM:
  - `out_valid`=1 and `in_ready`=0.
  - `out_x` = (bitrev(`cnt`) < num_r), where bitrev is the N-bit bit reversal (van der Corput source).
  - `out_y` = y_one_r ? 1 : (lfsr < den_r).
- Advance rule:
  - On `out_valid`&`out_ready`, `cnt` increments and the LFSR steps.
  - When `out_ready`=0, `cnt`, the LFSR and all outputs hold. The beat is never dropped or duplicated.
- `out_last` = STREAM & (`cnt`==2^N-1). When that beat is accepted, return to IDLE; `cnt` wraps to 0 but is unused.
- The LFSR is a de Bruijn (zero-inserted maximal) N-bit LFSR with period exactly 2^N, so each state is visited once per job. Consequences:
  - x carries exactly `in_num` ones per job.
  - y carries exactly `in_den` ones per job, or 2^N ones when `in_y_one`=1.
  - The x and y sources are uncorrelated by construction.
- Edge cases:
  - num=0 gives x all 0.
  - den=0 gives y all 0, which is bipolar -1 and legal. No special-casing.
  - den=2^(N-1) gives a bipolar-zero denominator. It is emitted as-is; flagging it is the downstream's responsibility.
- Inputs are sampled only at the accepting edge. Changes to `in_*` during STREAM have no effect.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_x`=0, `out_y`=0, `out_last`=0, state IDLE, `cnt`=0, LFSR=`Y_SEED`.
- Accept at edge k: `out_valid` is high from cycle k+1 carrying beat 0. The stream bits are combinational from registered state with no extra pipeline stage.
- Job throughput with `out_ready` held high: 2^N beats plus 1 IDLE cycle, i.e. 2^N+1 cycles. `in_ready` rises in the cycle after the last beat is accepted.
- Simultaneous events:
  - `in_valid` is held high across a job end: the next job is accepted on the IDLE cycle.
  - `out_ready` toggles on every beat: stream content is identical to the unstalled case and only timing stretches.
- Reset mid-stream: outputs drop to their reset values asynchronously. The partial job is discarded and there is no resume. After release, the block is in IDLE.

## Structure
- Shared package: de Bruijn tap constants indexed by N, and the FSM state enum (IDLE, STREAM). The width comes from the existing `BIN_LEN` define in sys_defs.
- Sub-module `debruijn_lfsr`:
  - Inputs: `clock`, `reset`, `load`, `seed`, `step`.
  - Output: N-bit `state`.
  - Reusable for other decorrelated sources.
- Top-level contains the FSM, counter, bit-reverse and the two comparators.

## Test plan
- N=8, num=128, y_one=1, `out_ready`=1 → x bits beat 0..3 = 1,0,1,0. Exactly 128 x-ones, 256 y-ones. `out_last` only on beat 255. `in_ready` high on the cycle after.
- num=0, den=255 → 0 x-ones and 255 y-ones over 256 beats. num=255, den=0 → 255 x-ones and 0 y-ones.
- num=100, den=37 with random `out_ready` (about 50% duty) → bit sequence identical to the unstalled run, 100/37 ones, no beat lost or repeated.
- Two jobs back-to-back with `in_valid` held → second job's beat 0 appears 2 cycles after the first job's last beat is accepted. Identical inputs give identical y streams (LFSR reseeded).
- Assert `reset` low at beat 60 of a job → `out_valid`=0 within the same cycle, `in_ready`=1 after release. The next job restarts at beat 0 with correct counts.
- Change `in_num` mid-stream → no effect on ones-count (equals the value latched at accept).

Source files
------------

// File: rtl/esl_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : esl_stream_encoder_pkg
// Brief    : Shared width, FSM state enum and de Bruijn LFSR tap table.
// Revision : 1.0
// ============================================================================
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

package esl_stream_encoder_pkg;

    localparam int BIN_LEN_C = `BIN_LEN;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } enc_state_e;

    // Fibonacci feedback masks of primitive polynomials; bit N-1 is always a tap,
    // which the zero-insertion term in debruijn_lfsr relies on.
    function automatic logic [31:0] debruijn_taps(input int n);
        logic [31:0] taps;
        case (n)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/esl_stream_encoder_debruijn_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : debruijn_lfsr
// Brief    : N-bit maximal LFSR with the all-zero state spliced in (period 2^N).
// Revision : 1.0
// ============================================================================
module debruijn_lfsr
    import esl_stream_encoder_pkg::*;
#(
    parameter int             N           = BIN_LEN_C,
    parameter logic [N-1:0]   RESET_STATE = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         step,
    output logic [N-1:0] state
);

    localparam logic [31:0]  TAPS_FULL = debruijn_taps(N);
    localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];

    logic [N-1:0] state_q;
    logic [N-1:0] state_d;
    logic         feedback;

    always_comb begin
        // Flipping feedback when only the MSB may be set routes 100..0 -> 0 -> 0..01.
        feedback = (^(state_q & TAPS)) ^ (state_q[N-2:0] == '0);
        state_d  = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = {state_q[N-2:0], feedback};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/esl_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : esl_stream_encoder
// Brief    : Binary operand pair to 2^N-beat ESL (x, y) bitstream encoder.
// Revision : 1.0
// ============================================================================
module esl_stream_encoder
    import esl_stream_encoder_pkg::*;
#(
    parameter int           N      = BIN_LEN_C,
    parameter logic [N-1:0] Y_SEED = N'(1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_num,
    input  logic [N-1:0] in_den,
    input  logic         in_y_one,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_x,
    output logic         out_y,
    output logic         out_last
);

    localparam logic [N-1:0] CNT_LAST = '1;

    enc_state_e   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] num_q, num_d;
    logic [N-1:0] den_q, den_d;
    logic         y_one_q, y_one_d;
    logic         lfsr_load;
    logic         lfsr_step;
    logic [N-1:0] lfsr_state;
    logic [N-1:0] cnt_rev;
    logic         streaming;

    debruijn_lfsr #(
        .N           (N),
        .RESET_STATE (Y_SEED)
    ) u_y_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (Y_SEED),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Van der Corput source: bit-reversed beat index spreads x ones evenly.
    for (genvar i = 0; i < N; i++) begin : g_bitrev
        assign cnt_rev[i] = cnt_q[N-1-i];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        den_d     = den_q;
        y_one_d   = y_one_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    num_d     = in_num;
                    den_d     = in_den;
                    y_one_d   = in_y_one;
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    cnt_d     = cnt_q + N'(1);
                    lfsr_step = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            y_one_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            den_q   <= den_d;
            y_one_q <= y_one_d;
        end
    end

    assign streaming = (state_q == ST_STREAM);
    assign in_ready  = ~streaming;
    assign out_valid = streaming;
    assign out_x     = streaming & (cnt_rev < num_q);
    assign out_y     = streaming & (y_one_q | (lfsr_state < den_q));
    assign out_last  = streaming & (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_esl_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_esl_stream_encoder
// Brief    : Directed and random jobs checked against ones-count / bit-order model.
// Revision : 1.0
// ============================================================================
module tb_esl_stream_encoder;

    localparam int N  = 8;
    localparam int NB = 1 << N;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_num = '0;
    logic [N-1:0] in_den = '0;
    logic         in_y_one = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_x;
    logic         out_y;
    logic         out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic xs   [NB];
    logic ys   [NB];
    logic xref [NB];
    logic yref [NB];

    always #5 clock = ~clock;

    esl_stream_encoder #(
        .N      (N),
        .Y_SEED (8'd1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .in_y_one  (in_y_one),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // x bit of beat b: reversed index below the numerator.
    function automatic logic model_x(input int beat, input int num);
        logic [N-1:0] b;
        int           rev;
        b   = beat[N-1:0];
        rev = 0;
        for (int i = 0; i < N; i++) rev = rev * 2 + int'(b[i]);
        return rev < num;
    endfunction

    // Runs one job from an IDLE cycle (positioned 1 time unit after a rising edge).
    task automatic run_job(input int num, input int den, input bit y_one, input bit stall,
                           input bit hold, input bit scramble, input int abort_at);
        int beat;
        int cyc;
        int xbad;
        int lastbad;
        int xo;
        int yo;
        beat = 0; cyc = 0; xbad = 0; lastbad = 0; xo = 0; yo = 0;
        check("idle_ready", {31'd0, in_ready}, 1);
        in_num   = num[N-1:0];
        in_den   = den[N-1:0];
        in_y_one = y_one;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = hold;
        check("first_valid", {31'd0, out_valid}, 1);
        while (beat < NB && cyc < 8 * NB) begin
            if (scramble) begin
                in_num   = N'($urandom);
                in_den   = N'($urandom);
                in_y_one = 1'($urandom);
            end
            if (abort_at >= 0 && beat == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_valid", {31'd0, out_valid}, 0);
                check("rst_ready", {31'd0, in_ready}, 1);
                check("rst_last", {31'd0, out_last}, 0);
                check("rst_xy", {30'd0, out_x, out_y}, 0);
                @(posedge clock); #1;
                reset = 1'b1;
                @(posedge clock); #1;
                check("rel_ready", {31'd0, in_ready}, 1);
                check("rel_valid", {31'd0, out_valid}, 0);
                return;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                xs[beat] = out_x;
                ys[beat] = out_y;
                if (out_x !== model_x(beat, num)) xbad++;
                if (out_last !== (beat == NB - 1)) lastbad++;
                beat++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check("beats", beat, NB);
        check("x_bits", xbad, 0);
        check("last_pos", lastbad, 0);
        for (int i = 0; i < NB; i++) begin
            xo += int'(xs[i]);
            yo += int'(ys[i]);
        end
        check("x_ones", xo, num);
        check("y_ones", yo, y_one ? NB : den);
        check("end_ready", {31'd0, in_ready}, 1);
        check("end_valid", {31'd0, out_valid}, 0);
    endtask

    function automatic int seq_diff(input bit use_x);
        int d;
        d = 0;
        for (int i = 0; i < NB; i++) begin
            if (use_x) d += int'(xs[i] !== xref[i]);
            else       d += int'(ys[i] !== yref[i]);
        end
        return d;
    endfunction

    initial begin
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_xyl", {29'd0, out_x, out_y, out_last}, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("idle_no_valid", {31'd0, out_valid}, 0);

        run_job(128, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check("x_beats_0_3", {28'd0, xs[0], xs[1], xs[2], xs[3]}, 32'b1010);

        run_job(0, 255, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_job(255, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        run_job(100, 37, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        xref = xs;
        yref = ys;
        run_job(100, 37, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check("stall_x_seq", seq_diff(1'b1), 0);
        check("stall_y_seq", seq_diff(1'b0), 0);

        run_job(200, 90, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        yref = ys;
        run_job(200, 90, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("b2b_y_seq", seq_diff(1'b0), 0);

        run_job(77, 150, 1'b0, 1'b0, 1'b0, 1'b0, 60);
        run_job(77, 150, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        run_job(50, 200, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        run_job(9, 128, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, NB - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
